// File: rtl/shift_sequencer_pkg.sv
// Shared types, widths and helpers for the multi-pass shift sequencer.
// The SHIFT_SEQ_RIGHT_EN build option is handled in shift_sequencer.sv.
package shift_sequencer_pkg;

    localparam int DATA_W   = 32;
    localparam int SHAMT_W  = 5;
    localparam int STEP_MAX = 7;
    localparam int STEP_W   = 3;
    localparam int SEL_W    = 5;
    localparam int PASS_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

    // Largest amount a single sll pass may take out of the remaining shift.
    function automatic logic [STEP_W-1:0] step_of(input logic [SHAMT_W-1:0] rem);
        if (rem > SHAMT_W'(STEP_MAX)) begin
            return STEP_W'(STEP_MAX);
        end
        return rem[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/shift_sequencer_sll.sv
// Combinational 32-bit logical-left barrel stage; zeros fill vacated LSBs.
// Built as log2 stages so each select bit drives one mux rank.
module shift_sequencer_sll
    import shift_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] sll_in,
    input  logic [SEL_W-1:0]  select,
    output logic [DATA_W-1:0] sll_out
);

    logic [DATA_W-1:0] s0;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
    logic [DATA_W-1:0] s3;

    assign s0      = select[0] ? {sll_in[DATA_W-2:0], 1'b0}  : sll_in;
    assign s1      = select[1] ? {s0[DATA_W-3:0], 2'b00}     : s0;
    assign s2      = select[2] ? {s1[DATA_W-5:0], 4'h0}      : s1;
    assign s3      = select[3] ? {s2[DATA_W-9:0], 8'h00}     : s2;
    assign sll_out = select[4] ? {s3[DATA_W-17:0], 16'h0000} : s3;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift controller that reuses one 0-7 bit sll stage per cycle.
// Define SHIFT_SEQ_RIGHT_EN to add in_dir and logical right shifts via bit reversal.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
`ifdef SHIFT_SEQ_RIGHT_EN
    input  logic               in_dir,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic [PASS_W-1:0]  passes,
    output logic [1:0]         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE, out_valid only in DONE; once
    // out_valid rises, out_data holds until out_ready takes it.

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [SHAMT_W-1:0] rem;
    logic [STEP_W-1:0]  step;
    logic [DATA_W-1:0]  sll_next;
    logic               accept;
    logic [DATA_W-1:0]  load_value;

    assign step   = step_of(rem);
    assign accept = in_valid && in_ready;

    shift_sequencer_sll u_sll (
        .sll_in  (acc),
        .select  ({2'b00, step}),
        .sll_out (sll_next)
    );

`ifdef SHIFT_SEQ_RIGHT_EN
    logic dir;

    // Right shifts run through the same left stage on a mirrored operand.
    assign load_value = in_dir ? bit_reverse(in_data) : in_data;
    assign out_data   = dir ? bit_reverse(acc) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir <= 1'b0;
        end else if (state == ST_IDLE && accept) begin
            dir <= in_dir;
        end
    end
`else
    assign load_value = in_data;
    assign out_data   = acc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            rem       <= '0;
            passes    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc      <= load_value;
                        rem      <= in_shamt;
                        passes   <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_shamt == '0) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc    <= sll_next;
                    rem    <= rem - SHAMT_W'(step);
                    passes <= passes + PASS_W'(1);
                    if (rem <= SHAMT_W'(STEP_MAX)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
